// File: rtl/readout_sched_pkg.sv
// Shared definitions for the readout scheduler: FSM encoding, source indices
// and default sizing.
package readout_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_XFER   = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  localparam int SRC_ALCT  = 0;
  localparam int SRC_TMB   = 1;
  localparam int SRC_CFEB0 = 2;
  localparam int NCFEB     = 7;
  localparam int NSRC_DEF  = 9;
  localparam int SEL_W     = 4;

endpackage

// File: rtl/prio_enc.sv
// Lowest-set-bit priority encoder: returns the index of the lowest pending
// source so readout always proceeds ALCT, TMB, CFEB0..6.
module prio_enc
  import readout_sched_pkg::*;
#(
  parameter int N = NSRC_DEF
) (
  input  logic [N-1:0]     i_req,
  output logic [SEL_W-1:0] o_idx,
  output logic             o_valid
);

  always_comb begin
    o_idx   = '0;
    o_valid = |i_req;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) o_idx = SEL_W'(i);
    end
  end

endmodule

// File: rtl/readout_sched.sv
// Event readout scheduler: drains each expected source FIFO in fixed priority
// order, abandoning a source that stalls for TMO_LIMIT unheld cycles.
module readout_sched
  import readout_sched_pkg::*;
#(
  parameter int NSRC      = NSRC_DEF,
  parameter int TMO_LIMIT = 1023,
  parameter int TMO_W     = 10
) (
  input  logic             i_clk,
  input  logic             i_rst_b,
  input  logic             i_start,
  input  logic             i_alct_flg,
  input  logic             i_tmb_flg,
  input  logic [NCFEB-1:0] i_cfeb_act,
  input  logic [NSRC-1:0]  i_src_mt,
  input  logic [NSRC-1:0]  i_src_last,
  input  logic             i_hold,
  output logic [NSRC-1:0]  o_rd_en,
  output logic [SEL_W-1:0] o_src_sel,
  output logic             o_data_ce,
  output logic             o_busy,
  output logic             o_done,
  output logic [NSRC-1:0]  o_tmo_err
);

  localparam logic [TMO_W-1:0] LIMIT = TMO_W'(TMO_LIMIT);

  state_t            r_state, w_state_next;
  logic [NSRC-1:0]   r_pend, w_pend_next;
  logic [TMO_W-1:0]  r_timer, w_timer_next;
  logic [SEL_W-1:0]  r_src_sel, w_sel_next;
  logic [NSRC-1:0]   r_tmo_err, w_tmo_next;
  logic              r_busy, w_busy_next;
  logic              r_done, w_done_next;
  logic              r_data_ce;
  logic [NSRC-1:0]   w_rd_en;
  logic [NSRC-1:0]   w_flags;
  logic [SEL_W-1:0]  w_enc_idx;
  logic              w_enc_valid;
  logic              w_pop;
  logic              w_head_last;

  prio_enc #(.N(NSRC)) u_prio_enc (
    .i_req   (r_pend),
    .o_idx   (w_enc_idx),
    .o_valid (w_enc_valid)
  );

  always_comb begin
    w_flags                      = '0;
    w_flags[SRC_ALCT]            = i_alct_flg;
    w_flags[SRC_TMB]             = i_tmb_flg;
    w_flags[SRC_CFEB0 +: NCFEB]  = i_cfeb_act;
  end

  assign w_pop       = (r_state == ST_XFER) && !i_src_mt[r_src_sel] && !i_hold;
  assign w_head_last = i_src_last[r_src_sel];

  always_comb begin
    w_state_next = r_state;
    w_pend_next  = r_pend;
    w_timer_next = r_timer;
    w_sel_next   = r_src_sel;
    w_tmo_next   = r_tmo_err;
    w_busy_next  = r_busy;
    w_done_next  = 1'b0;
    w_rd_en      = '0;

    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_pend_next  = w_flags;
          w_tmo_next   = '0;
          w_busy_next  = 1'b1;
          w_state_next = ST_SELECT;
        end
      end

      ST_SELECT: begin
        if (w_enc_valid) begin
          w_sel_next   = w_enc_idx;
          w_timer_next = '0;
          w_state_next = ST_XFER;
        end else begin
          w_done_next  = 1'b1;
          w_state_next = ST_FINISH;
        end
      end

      ST_XFER: begin
        // A pop always beats the timeout, including a last-word pop at the limit.
        if (w_pop) begin
          w_rd_en[r_src_sel] = 1'b1;
          w_timer_next       = '0;
          if (w_head_last) begin
            w_pend_next[r_src_sel] = 1'b0;
            w_state_next           = ST_SELECT;
          end
        end else if (r_timer == LIMIT) begin
          w_tmo_next[r_src_sel]  = 1'b1;
          w_pend_next[r_src_sel] = 1'b0;
          w_state_next           = ST_SELECT;
        end else if (!i_hold) begin
          w_timer_next = r_timer + 1'b1;
        end
      end

      ST_FINISH: begin
        w_busy_next  = 1'b0;
        w_state_next = ST_IDLE;
      end

      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      r_state   <= ST_IDLE;
      r_pend    <= '0;
      r_timer   <= '0;
      r_src_sel <= '0;
      r_tmo_err <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_data_ce <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_pend    <= w_pend_next;
      r_timer   <= w_timer_next;
      r_src_sel <= w_sel_next;
      r_tmo_err <= w_tmo_next;
      r_busy    <= w_busy_next;
      r_done    <= w_done_next;
      r_data_ce <= |w_rd_en;
    end
  end

  assign o_rd_en   = w_rd_en;
  assign o_src_sel = r_src_sel;
  assign o_data_ce = r_data_ce;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_tmo_err = r_tmo_err;

endmodule

// File: doc/readout_sched.md
READOUT_SCHED -- requirements
Module: readout_sched

Interface
REQ-001 Parameter NSRC, default 9, number of readout sources: bit 0 ALCT, bit 1 TMB, bits 2..8 CFEB0..CFEB6.
REQ-002 Parameter TMO_LIMIT, default 1023, number of XFER cycles without a pop before a source is abandoned.
REQ-003 Parameter TMO_W, default 10, width of the timeout counter.
REQ-004 CLK  in  1  sole clock; all state changes on the rising edge.
REQ-005 RST_B  in  1  reset, asynchronous assert, active-low.
REQ-006 START  in  1  one-cycle pulse from the L1A checker; begins readout of one event.
REQ-007 ALCT_FLG  in  1  ALCT data is expected for this event.
REQ-008 TMB_FLG  in  1  TMB data is expected for this event.
REQ-009 CFEB_ACT  in  7  per-CFEB data expected for this event.
REQ-010 SRC_MT  in  NSRC  per-source FIFO empty (FWFT FIFOs).
REQ-011 SRC_LAST  in  NSRC  word at the FIFO head is the last word of the event for that source.
REQ-012 HOLD  in  1  downstream backpressure; no pop while high.
REQ-013 RD_EN  out  NSRC  one-hot FIFO pop, combinational from state and inputs.
REQ-014 SRC_SEL  out  4  binary index of the granted source, registered; drives the data mux.
REQ-015 DATA_CE  out  1  downstream word valid, registered OR of RD_EN (one cycle after the pop).
REQ-016 BUSY  out  1  high from START acceptance through the DONE cycle.
REQ-017 DONE  out  1  one-cycle pulse at the end of the event.
REQ-018 TMO_ERR  out  NSRC  per-source timeout flags, sticky until the next accepted START.

Function
REQ-019 The FSM SHALL have the states IDLE, SELECT, XFER and FINISH.
REQ-020 IDLE with START=1: SHALL latch PEND={CFEB_ACT,TMB_FLG,ALCT_FLG}, clear TMO_ERR, set BUSY, and go to SELECT next cycle.
REQ-021 START outside IDLE SHALL be ignored, with no effect on PEND, TMO_ERR or state.
REQ-022 SELECT with PEND≠0: SHALL load SRC_SEL with the lowest set PEND index, clear the timer, and go to XFER.
REQ-023 SELECT with PEND=0: SHALL go to FINISH.
REQ-024 Readout order is therefore ALCT, TMB, CFEB0..6; skipped sources cost no cycles beyond one SELECT.
REQ-025 XFER: RD_EN[SRC_SEL] = !SRC_MT[SRC_SEL] && !HOLD; all other RD_EN bits are 0.
REQ-026 XFER: a pop with SRC_LAST[SRC_SEL]=1 SHALL clear PEND[SRC_SEL] and go to SELECT.
REQ-027 XFER: the timer SHALL increment each cycle with no pop and HOLD=0, SHALL hold its value while HOLD=1, and SHALL reset to 0 on every pop.
REQ-028 XFER: when the timer reaches TMO_LIMIT, SHALL set TMO_ERR[SRC_SEL], clear PEND[SRC_SEL] and go to SELECT with no pop that cycle.
REQ-029 If a last-word pop and timer=TMO_LIMIT occur in the same cycle, the pop SHALL win and no TMO_ERR is set.
REQ-030 FINISH: SHALL pulse DONE for one cycle, deassert BUSY on the next cycle, and go to IDLE.
REQ-031 START arriving in the FINISH cycle SHALL be ignored.
REQ-032 Latency: START at edge k gives SRC_SEL valid at k+1 and the first possible RD_EN in cycle k+2.
REQ-033 Latency: a last-word pop is followed by exactly one SELECT gap cycle with RD_EN=0.
REQ-034 The timer SHALL saturate at TMO_LIMIT and never wrap.
REQ-035 TMO_W SHALL be ≥ clog2(TMO_LIMIT+1).
REQ-036 RD_EN SHALL be all-zero in IDLE, SELECT and FINISH.

Reset
REQ-037 RST_B low SHALL asynchronously force state IDLE, PEND=0, timer=0, SRC_SEL=0, DATA_CE=0, BUSY=0, DONE=0 and TMO_ERR=0.
REQ-038 RD_EN SHALL read 0 while RST_B is low.
REQ-039 Reset mid-event SHALL abandon the event without a DONE pulse.
REQ-040 After RST_B rises, the first rising edge SHALL sample START normally.

Structure
REQ-041 A shared package SHALL hold the state encoding, the source index constants (SRC_ALCT=0, SRC_TMB=1, SRC_CFEB0=2) and the NSRC default.
REQ-042 A lowest-set-bit priority encoder (NSRC to 4 bits) SHALL be the single sub-module, named prio_enc.
REQ-043 Target size: 120-400 lines of RTL.

Verification
REQ-044 Scenario 1: ALCT_FLG=1, TMB_FLG=0, CFEB_ACT=7'b0000101, each FIFO holds 3 words with the last flagged, START -> SRC_SEL sequence 0,2,4; 9 pops; DONE pulse; TMO_ERR=0.
REQ-045 Scenario 2: all flags 0, START -> DONE exactly 2 cycles after START; no RD_EN ever asserted.
REQ-046 Scenario 3: TMB_FLG=1, TMB FIFO empty throughout -> TMO_ERR[1]=1 after 1023 idle XFER cycles; DONE follows; TMO_ERR cleared by the next START.
REQ-047 Scenario 4: CFEB0 streaming with HOLD high for 2000 cycles -> no pops, no timeout; after HOLD falls, streaming resumes with DATA_CE one cycle after each RD_EN.
REQ-048 Scenario 5: RST_B pulsed low mid-XFER on CFEB3 -> all outputs 0 immediately; no DONE; a following START runs a clean event.
REQ-049 Scenario 6: second START asserted during XFER -> ignored; exactly one DONE per accepted START.
